// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Provides fetch_entry_t {pc, inst} and the HALT opcode pattern.
package ifetch_pkg;

  localparam int INST_WIDTH = 16;
  localparam int PC_WIDTH = 16;
  localparam int PC_INCR = 2;
  localparam logic [4:0] HALT_OPCODE = 5'b00000;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_halt(
    input logic [INST_WIDTH-1:0] w
  );
    return w[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch bus bundle: instruction memory port plus decode valid/ready.
// master = fetch unit side, slave = memory/decode side.
interface ifetch_if #(
  parameter int ADDR_WIDTH = 16
);
  import ifetch_pkg::*;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [INST_WIDTH-1:0] mem_rdata;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;

  modport master (
    output mem_addr, mem_enable, mem_wr,
    output inst_valid, inst, inst_pc,
    input  mem_rdata, inst_ready
  );

  modport slave (
    input  mem_addr, mem_enable, mem_wr,
    input  inst_valid, inst, inst_pc,
    output mem_rdata, inst_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: push/pop/flush, count and head (flush beats push/pop).
// Ports: clk, rst, push_i, data_i, pop_i, flush_i, count_o, head_o.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output entry_t        head_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  // Pop on empty is ignored; push at full only
  // succeeds alongside a pop.
  always_comb begin
    pop_ok  = pop_i & (cnt_q != '0);
    push_ok = push_i &
      ((cnt_q < CW'(DEPTH)) | pop_ok);
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_ok)
                    - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i && push_ok)
      mem_q[wr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, one aligned read/cycle, prefetch FIFO, redirect.
// Ports: clk, rst, fetch_en, redirect_valid/pc, halted, bus (ifetch_if.master).
// Optional HALT detection enabled by macro IFETCH_HALT_DETECT_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted,
  ifetch_if.master              bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         count;
  entry_t                head;
  entry_t                push_data;
  logic                  inst_valid;
  logic                  pop;
  logic                  fetch;
  logic                  halted_q;
  logic                  unused_pc0;

  assign unused_pc0 = redirect_pc[0];

  assign inst_valid = (count != '0);
  assign pop = inst_valid & bus.inst_ready;

  // A pop frees a slot in the same cycle,
  // so a full FIFO still sustains 1/cycle.
  always_comb begin
    fetch = !rst & fetch_en & !redirect_valid
          & !halted_q
          & ((count < CW'(FIFO_DEPTH)) | pop);
    push_data.pc   = pc_q;
    push_data.inst = bus.mem_rdata;
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
    else if (fetch)
      pc_d = pc_q + ADDR_WIDTH'(PC_INCR);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

`ifdef IFETCH_HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst)
      halted_q <= 1'b0;
    else if (redirect_valid)
      halted_q <= 1'b0;
    else if (fetch && is_halt(bus.mem_rdata))
      halted_q <= 1'b1;
  end
`else
  assign halted_q = 1'b0;
`endif

  ifetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fetch),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (count),
    .head_o  (head)
  );

  assign halted         = halted_q;
  assign bus.mem_addr   = pc_q;
  assign bus.mem_enable = fetch;
  assign bus.mem_wr     = 1'b0;
  assign bus.inst_valid = inst_valid;
  assign bus.inst    = inst_valid ? head.inst : '0;
  assign bus.inst_pc = inst_valid ? head.pc : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit with a scoreboard of fetched words.
// Memory model is a combinational-read word array.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halted;

  ifetch_if #(.ADDR_WIDTH(16)) bus();

  logic [15:0] memarr [0:32767];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  fetch_entry_t sbq[$];
  logic [15:0]  m_pc = '0;
  logic         m_halted = 1'b0;
  logic         m_valid, m_pop, m_fetch;

  always #5 clk = ~clk;

  assign bus.mem_rdata = memarr[bus.mem_addr[15:1]];

  ifetch_unit #(
    .ADDR_WIDTH (16),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .bus            (bus)
  );

  // Scoreboard: expected {pc,inst} pushed when a fetch
  // is predicted, popped when decode consumes the head.
  always @(negedge clk) begin
    if (mon_en) begin
      m_valid = (sbq.size() != 0);
      checks++;
      if (bus.inst_valid !== m_valid) begin
        errors++;
        $display("FAIL sb_valid got=%b exp=%b t=%0t",
          bus.inst_valid, m_valid, $time);
      end
      checks++;
      if (m_valid) begin
        if (bus.inst !== sbq[0].inst ||
            bus.inst_pc !== sbq[0].pc) begin
          errors++;
          $display("FAIL sb_head got=%h@%h exp=%h@%h",
            bus.inst, bus.inst_pc,
            sbq[0].inst, sbq[0].pc);
        end
      end else if (bus.inst !== 16'h0 ||
                   bus.inst_pc !== 16'h0) begin
        errors++;
        $display("FAIL sb_idle got=%h@%h exp=0000@0000",
          bus.inst, bus.inst_pc);
      end
      m_pop = m_valid && bus.inst_ready;
      m_fetch = !rst && fetch_en && !redirect_valid
        && !m_halted && (sbq.size() < DEPTH || m_pop);
      checks++;
      if (bus.mem_enable !== m_fetch) begin
        errors++;
        $display("FAIL sb_en got=%b exp=%b t=%0t",
          bus.mem_enable, m_fetch, $time);
      end
      checks++;
      if (bus.mem_addr !== m_pc) begin
        errors++;
        $display("FAIL sb_addr got=%h exp=%h t=%0t",
          bus.mem_addr, m_pc, $time);
      end
      checks++;
      if (bus.mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL sb_wr got=%b exp=0", bus.mem_wr);
      end
      checks++;
      if (halted !== m_halted) begin
        errors++;
        $display("FAIL sb_halted got=%b exp=%b",
          halted, m_halted);
      end
      if (rst) begin
        sbq.delete();
        m_pc = 16'h0000;
        m_halted = 1'b0;
      end else if (redirect_valid) begin
        sbq.delete();
        m_pc = {redirect_pc[15:1], 1'b0};
        m_halted = 1'b0;
      end else begin
        if (m_pop) void'(sbq.pop_front());
        if (m_fetch) begin
          sbq.push_back('{pc: m_pc,
            inst: memarr[m_pc[15:1]]});
`ifdef IFETCH_HALT_DETECT_EN
          if (memarr[m_pc[15:1]][15:11] == 5'b0)
            m_halted = 1'b1;
`endif
          m_pc = m_pc + 16'd2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    smp();
    checks++;
    if (bus.mem_enable !== 1'b0 ||
        bus.inst_valid !== 1'b0 ||
        bus.inst !== 16'h0 ||
        bus.inst_pc !== 16'h0 ||
        bus.mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset en=%b v=%b i=%h pc=%h a=%h exp 0",
        bus.mem_enable, bus.inst_valid,
        bus.inst, bus.inst_pc, bus.mem_addr);
    end
    tick();
  endtask

  task automatic test_stream();
    rst = 1'b0;
    fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    smp();
    checks++;
    if (bus.mem_addr !== 16'h0 ||
        bus.mem_enable !== 1'b1 ||
        bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream0 a=%h en=%b v=%b exp 0000/1/0",
        bus.mem_addr, bus.mem_enable, bus.inst_valid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      smp();
      checks++;
      if (bus.inst_valid !== 1'b1 ||
          bus.inst !== 16'h1111 * (i + 1) ||
          bus.inst_pc !== 16'(2 * i) ||
          bus.mem_addr !== 16'(2 * i + 2)) begin
        errors++;
        $display("FAIL stream%0d i=%h pc=%h a=%h exp %h/%h/%h",
          i + 1, bus.inst, bus.inst_pc, bus.mem_addr,
          16'h1111 * (i + 1), 2 * i, 2 * i + 2);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    bus.inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      smp();
      checks++;
      if (bus.mem_enable !== 1'b1 ||
          bus.mem_addr !== 16'(2 * i)) begin
        errors++;
        $display("FAIL bp_fill en=%b a=%h exp 1/%h",
          bus.mem_enable, bus.mem_addr, 2 * i);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      smp();
      checks++;
      if (bus.mem_enable !== 1'b0 ||
          bus.mem_addr !== 16'h0008 ||
          bus.inst_pc !== 16'h0000) begin
        errors++;
        $display("FAIL bp_full en=%b a=%h pc=%h exp 0/0008/0000",
          bus.mem_enable, bus.mem_addr, bus.inst_pc);
      end
      tick();
    end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      smp();
      checks++;
      if (bus.mem_enable !== 1'b1 ||
          bus.mem_addr !== 16'(8 + 2 * i) ||
          bus.inst_pc !== 16'(2 * i)) begin
        errors++;
        $display("FAIL bp_flow en=%b a=%h pc=%h exp 1/%h/%h",
          bus.mem_enable, bus.mem_addr, bus.inst_pc,
          8 + 2 * i, 2 * i);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    bus.inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0041;
    smp();
    checks++;
    if (bus.mem_enable !== 1'b0 ||
        bus.inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_cyc en=%b v=%b exp 0/1",
        bus.mem_enable, bus.inst_valid);
    end
    tick();
    redirect_valid = 1'b0;
    bus.inst_ready = 1'b1;
    smp();
    checks++;
    if (bus.inst_valid !== 1'b0 ||
        bus.mem_addr !== 16'h0040 ||
        bus.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL redir_next v=%b a=%h en=%b exp 0/0040/1",
        bus.inst_valid, bus.mem_addr, bus.mem_enable);
    end
    tick();
    smp();
    checks++;
    if (bus.inst_valid !== 1'b1 ||
        bus.inst_pc !== 16'h0040) begin
      errors++;
      $display("FAIL redir_head v=%b pc=%h exp 1/0040",
        bus.inst_valid, bus.inst_pc);
    end
    tick();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    bus.inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    smp();
    checks++;
    if (bus.mem_addr !== 16'hFFFE ||
        bus.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL wrap_a0 a=%h en=%b exp FFFE/1",
        bus.mem_addr, bus.mem_enable);
    end
    tick();
    smp();
    checks++;
    if (bus.mem_addr !== 16'h0000 ||
        bus.inst_pc !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_a1 a=%h pc=%h exp 0000/FFFE",
        bus.mem_addr, bus.inst_pc);
    end
    tick();
    smp();
    checks++;
    if (bus.inst_pc !== 16'h0000 ||
        bus.inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pc pc=%h v=%b exp 0000/1",
        bus.inst_pc, bus.inst_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    bus.inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    smp();
    checks++;
    if (bus.mem_enable !== 1'b0 ||
        bus.mem_wr !== 1'b0 ||
        bus.mem_addr !== 16'h0014) begin
      errors++;
      $display("FAIL rstmid en=%b wr=%b a=%h exp 0/0/0014",
        bus.mem_enable, bus.mem_wr, bus.mem_addr);
    end
    tick();
    rst = 1'b0;
    smp();
    checks++;
    if (bus.inst_valid !== 1'b0 ||
        bus.mem_addr !== 16'h0000 ||
        bus.mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after v=%b a=%h en=%b exp 0/0000/1",
        bus.inst_valid, bus.mem_addr, bus.mem_enable);
    end
    tick();
  endtask

  task automatic test_fetch_en();
    fetch_en = 1'b0;
    bus.inst_ready = 1'b1;
    smp();
    checks++;
    if (bus.mem_enable !== 1'b0 ||
        bus.mem_addr !== 16'h0002 ||
        bus.inst_pc !== 16'h0000) begin
      errors++;
      $display("FAIL fen_drain en=%b a=%h pc=%h exp 0/0002/0000",
        bus.mem_enable, bus.mem_addr, bus.inst_pc);
    end
    tick();
    smp();
    checks++;
    if (bus.inst_valid !== 1'b0 ||
        bus.mem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL fen_hold v=%b a=%h exp 0/0002",
        bus.inst_valid, bus.mem_addr);
    end
    tick();
    fetch_en = 1'b1;
  endtask

`ifdef IFETCH_HALT_DETECT_EN
  task automatic test_halt();
    memarr[3] = 16'h0000;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    bus.inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++;
      if (bus.mem_enable !== 1'b1 ||
          bus.mem_addr !== 16'(2 * i)) begin
        errors++;
        $display("FAIL halt_fetch en=%b a=%h exp 1/%h",
          bus.mem_enable, bus.mem_addr, 2 * i);
      end
      tick();
    end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++;
      if (halted !== 1'b1 ||
          bus.mem_enable !== 1'b0 ||
          bus.inst_pc !== 16'(2 * i)) begin
        errors++;
        $display("FAIL halt_drain h=%b en=%b pc=%h exp 1/0/%h",
          halted, bus.mem_enable, bus.inst_pc, 2 * i);
      end
      tick();
    end
    smp();
    checks++;
    if (bus.inst_valid !== 1'b0 ||
        bus.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL halt_empty v=%b en=%b exp 0/0",
        bus.inst_valid, bus.mem_enable);
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    memarr[3] = 16'h8003;
    smp();
    checks++;
    if (halted !== 1'b0 ||
        bus.mem_enable !== 1'b1 ||
        bus.mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL halt_clear h=%b en=%b a=%h exp 0/1/0000",
        halted, bus.mem_enable, bus.mem_addr);
    end
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 32768; i++)
      memarr[i] = 16'h8000 | 16'(i);
    memarr[0] = 16'h1111;
    memarr[1] = 16'h2222;
    memarr[2] = 16'h3333;
    bus.inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_fetch_en();
`ifdef IFETCH_HALT_DETECT_EN
    test_halt();
`endif
    tick();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule
